// File: rtl/bombe_search.sv
// Crib search: buffers CRIB_LEN letter pairs and sweeps all NUM_ROTORS start settings via external enc_* core; BOMBE_ALL_SOLUTIONS_EN keeps sweeping past hits.
// Latency: (matched+1) CHECK cycles + 1 INCR per candidate; pair_ready is high only in IDLE with room in the buffer.
module bombe_search #(
  parameter int CRIB_LEN   = 3,
  parameter int NUM_ROTORS = 3,
  localparam int SW        = 5 * NUM_ROTORS
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          pair_valid,
  input  logic [7:0]    plain_in,
  input  logic [7:0]    cipher_in,
  output logic          pair_ready,
  input  logic          start,
  output logic [SW-1:0] enc_pos,
  output logic [4:0]    enc_char,
  input  logic [4:0]    enc_result,
  output logic          busy,
  output logic          found,
  output logic [SW-1:0] setting_out,
  output logic          done,
  output logic          fail
`ifdef BOMBE_ALL_SOLUTIONS_EN
  , output logic [15:0] hit_count
`endif
);

  localparam int IW = (CRIB_LEN > 1) ? $clog2(CRIB_LEN) : 1;
  localparam int CW = $clog2(CRIB_LEN + 1);

  typedef enum logic [1:0] {IDLE, CHECK, INCR, FINISH} state_t;

  state_t        state, state_n;
  logic [4:0]    plain_mem  [CRIB_LEN];
  logic [4:0]    cipher_mem [CRIB_LEN];
  logic [CW-1:0] count;
  logic [IW-1:0] idx, idx_n;
  logic [SW-1:0] base, base_n, cur_n, base_step;
  logic          load, launch, hit, hit_any;

  // Odometer: a slot advances only when every lower slot wraps 25 -> 0.
  function automatic logic [SW-1:0] step(input logic [SW-1:0] p);
    logic [SW-1:0] r;
    logic          carry;
    r     = p;
    carry = 1'b1;
    for (int k = 0; k < NUM_ROTORS; k++) begin
      if (carry) begin
        if (p[5*k +: 5] == 5'd25) begin
          r[5*k +: 5] = 5'd0;
        end else begin
          r[5*k +: 5] = p[5*k +: 5] + 5'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic letter_ok(input logic [7:0] b);
    return (b >= 8'h41) && (b <= 8'h5A);
  endfunction

  function automatic logic [4:0] letter_idx(input logic [7:0] b);
    logic [7:0] d;
    d = b - 8'h41;
    return d[4:0];
  endfunction

  assign pair_ready = (state == IDLE) && (count < CW'(CRIB_LEN));
  assign load       = pair_valid && pair_ready && letter_ok(plain_in) && letter_ok(cipher_in);
  assign busy       = (state == CHECK) || (state == INCR);
  assign done       = (state == FINISH) && hit_any;
  assign fail       = (state == FINISH) && !hit_any;
  assign base_step  = step(base);

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    base_n  = base;
    cur_n   = enc_pos;
    idx_n   = idx;
    hit     = 1'b0;
    launch  = 1'b0;
    case (state)
      IDLE:   launch = start && (count == CW'(CRIB_LEN));
      CHECK: begin
        if (enc_result == cipher_mem[idx]) begin
          if (idx == IW'(CRIB_LEN - 1)) begin
            hit = 1'b1;
`ifdef BOMBE_ALL_SOLUTIONS_EN
            state_n = INCR;
`else
            state_n = FINISH;
`endif
          end else begin
            idx_n = idx + 1'b1;
            cur_n = step(enc_pos);
          end
        end else begin
          state_n = INCR;
        end
      end
      INCR: begin
        base_n  = base_step;
        cur_n   = base_step;
        idx_n   = '0;
        state_n = (base_step == '0) ? FINISH : CHECK;
      end
      FINISH: launch = start;
      default: state_n = IDLE;
    endcase
    if (launch) begin
      state_n = CHECK;
      base_n  = '0;
      cur_n   = '0;
      idx_n   = '0;
    end
  end

  // Buffer contents need no reset: count alone decides what is valid.
  always_ff @(posedge clock) begin
    if (load) begin
      plain_mem[count[IW-1:0]]  <= letter_idx(plain_in);
      cipher_mem[count[IW-1:0]] <= letter_idx(cipher_in);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count       <= '0;
      base        <= '0;
      idx         <= '0;
      enc_pos     <= '0;
      enc_char    <= '0;
      found       <= 1'b0;
      setting_out <= '0;
      hit_any     <= 1'b0;
    end else begin
      if (load) count <= count + 1'b1;
      base     <= base_n;
      idx      <= idx_n;
      enc_pos  <= (state_n == CHECK) ? cur_n : '0;
      enc_char <= (state_n == CHECK) ? plain_mem[idx_n] : '0;
      found    <= hit;
      if (hit) setting_out <= base;
      if (launch)   hit_any <= 1'b0;
      else if (hit) hit_any <= 1'b1;
    end
  end

`ifdef BOMBE_ALL_SOLUTIONS_EN
  always_ff @(posedge clock) begin
    if (reset || launch) hit_count <= '0;
    else if (hit)        hit_count <= hit_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_bombe_search.sv
// Bench for bombe_search with a stub core enc = (char + pos0 + pos1) % 26, NUM_ROTORS = 2.
module tb_bombe_search;
  localparam int CL = 3;
  localparam int NR = 2;
  localparam int SW = 5 * NR;

  logic          clock = 1'b0;
  logic          reset, pair_valid, start;
  logic [7:0]    plain_in, cipher_in;
  logic          pair_ready, busy, found, done, fail;
  logic [SW-1:0] enc_pos, setting_out;
  logic [4:0]    enc_char, enc_result;
`ifdef BOMBE_ALL_SOLUTIONS_EN
  logic [15:0]   hit_count;
`endif

  always #5 clock = ~clock;

  assign enc_result = 5'((int'(enc_char) + int'(enc_pos[4:0]) + int'(enc_pos[9:5])) % 26);

  bombe_search #(.CRIB_LEN(CL), .NUM_ROTORS(NR)) dut (
    .clock(clock), .reset(reset), .pair_valid(pair_valid), .plain_in(plain_in),
    .cipher_in(cipher_in), .pair_ready(pair_ready), .start(start), .enc_pos(enc_pos),
    .enc_char(enc_char), .enc_result(enc_result), .busy(busy), .found(found),
    .setting_out(setting_out), .done(done), .fail(fail)
`ifdef BOMBE_ALL_SOLUTIONS_EN
    , .hit_count(hit_count)
`endif
  );

  typedef struct {
    logic       vld;
    logic [7:0] p;
    logic [7:0] c;
    logic       st;
    logic       exp_ready;
    logic       exp_busy;
  } vec_t;

  int            n_chk = 0;
  int            n_pass = 0;
  logic [SW-1:0] exp_q [$];
  int            m_plain  [CL];
  int            m_cipher [CL];
  vec_t          vt [8];
  int            first_lat, end_cyc, hits;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic load_pair(input logic [7:0] p, input logic [7:0] c);
    pair_valid = 1'b1;
    plain_in   = p;
    cipher_in  = c;
    tick();
    pair_valid = 1'b0;
  endtask

  function automatic bit model_match(input int b, input int i);
    int c, p0, p1;
    c  = (b + i) % 676;
    p0 = c % 26;
    p1 = c / 26;
    return ((m_plain[i] + p0 + p1) % 26) == m_cipher[i];
  endfunction

  // Expected hit settings go to the scoreboard; cycle counts are relative to the start edge.
  task automatic model_sweep(output int f_lat, output int e_cyc, output int n_hits);
    int t, m;
    t = 0; f_lat = -1; e_cyc = -1; n_hits = 0;
    exp_q.delete();
    for (int b = 0; b < 676; b++) begin
      m = 0;
      while (m < CL && model_match(b, m)) m++;
      if (m == CL) begin
        n_hits++;
        exp_q.push_back(SW'(((b / 26) << 5) | (b % 26)));
        if (f_lat < 0) f_lat = t + CL;
`ifdef BOMBE_ALL_SOLUTIONS_EN
        t += CL + 1;
`else
        e_cyc = t + CL;
        break;
`endif
      end else begin
        t += m + 2;
      end
    end
    if (e_cyc < 0) e_cyc = t;
  endtask

  task automatic run_search(input string tag);
    int            cyc, got;
    bit            ended;
    logic [SW-1:0] e;
    cyc = 0; got = 0; ended = 1'b0;
    while (!ended && cyc < 20000) begin
      tick();
      cyc++;
      if (found) begin
        got++;
        if (exp_q.size() == 0) begin
          chk({tag, "_extra_found"}, 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk({tag, "_setting"}, int'(setting_out), int'(e));
        end
        if (got == 1) chk({tag, "_first_latency"}, cyc, first_lat);
      end
      if (done || fail) ended = 1'b1;
    end
    chk({tag, "_ended"}, int'(ended), 1);
    chk({tag, "_end_cycle"}, cyc, end_cyc);
    chk({tag, "_done"}, int'(done), int'(hits > 0));
    chk({tag, "_fail"}, int'(fail), int'(hits == 0));
    chk({tag, "_missing_found"}, exp_q.size(), 0);
    chk({tag, "_busy_idle"}, int'(busy), 0);
    chk({tag, "_enc_pos_idle"}, int'(enc_pos), 0);
`ifdef BOMBE_ALL_SOLUTIONS_EN
    chk({tag, "_hit_count"}, int'(hit_count), hits);
`else
    chk({tag, "_found_pulses"}, got, (hits > 0) ? 1 : 0);
`endif
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    reset = 1'b1; pair_valid = 1'b0; start = 1'b0; plain_in = '0; cipher_in = '0;
    tick(); tick();
    reset = 1'b0;
    chk("rst_busy", int'(busy), 0);
    chk("rst_found", int'(found), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_fail", int'(fail), 0);
    chk("rst_pair_ready", int'(pair_ready), 1);
    chk("rst_setting_out", int'(setting_out), 0);
    chk("rst_enc_pos", int'(enc_pos), 0);
    chk("rst_enc_char", int'(enc_char), 0);

    // Crib with a known solution, then a rerun from FINISH on the same buffer.
    m_plain  = '{0, 1, 2};
    m_cipher = '{3, 5, 7};
    load_pair("A", "D");
    load_pair("B", "F");
    load_pair("C", "H");
    chk("full_pair_ready", int'(pair_ready), 0);
    model_sweep(first_lat, end_cyc, hits);
    start = 1'b1; tick(); start = 1'b0;
    chk("hit_busy_after_start", int'(busy), 1);
    run_search("hit");
    model_sweep(first_lat, end_cyc, hits);
    start = 1'b1; tick(); start = 1'b0;
    run_search("rerun");

    // Reset one cycle before the first hit would register.
    start = 1'b1; tick(); start = 1'b0;
    repeat (first_lat - 1) tick();
    chk("midrst_busy_before", int'(busy), 1);
    reset = 1'b1; tick(); reset = 1'b0;
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_pair_ready", int'(pair_ready), 1);
    chk("midrst_found", int'(found), 0);
    chk("midrst_setting_out", int'(setting_out), 0);
    start = 1'b1; tick(); start = 1'b0;
    chk("midrst_start_ignored", int'(busy), 0);
    seen = 0;
    repeat (12) begin
      tick();
      if (found || busy) seen++;
    end
    chk("midrst_no_activity", seen, 0);

    // Load rules, partial-buffer start, then a crib with no solution.
    vt[0] = '{1'b1, "1", "D", 1'b0, 1'b1, 1'b0};
    vt[1] = '{1'b1, "A", "D", 1'b0, 1'b1, 1'b0};
    vt[2] = '{1'b1, "B", "z", 1'b0, 1'b1, 1'b0};
    vt[3] = '{1'b1, "B", "D", 1'b0, 1'b1, 1'b0};
    vt[4] = '{1'b0, "C", "D", 1'b1, 1'b1, 1'b0};
    vt[5] = '{1'b1, "C", "D", 1'b0, 1'b0, 1'b0};
    vt[6] = '{1'b1, "E", "E", 1'b0, 1'b0, 1'b0};
    vt[7] = '{1'b1, "D", "D", 1'b1, 1'b0, 1'b1};
    m_plain  = '{0, 1, 2};
    m_cipher = '{3, 3, 3};
    model_sweep(first_lat, end_cyc, hits);
    for (int i = 0; i < 8; i++) begin
      pair_valid = vt[i].vld;
      plain_in   = vt[i].p;
      cipher_in  = vt[i].c;
      start      = vt[i].st;
      tick();
      pair_valid = 1'b0;
      start      = 1'b0;
      chk($sformatf("vec%0d_pair_ready", i), int'(pair_ready), int'(vt[i].exp_ready));
      chk($sformatf("vec%0d_busy", i), int'(busy), int'(vt[i].exp_busy));
    end
    run_search("sweep");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
